// File: rtl/index_mask_builder_pkg.sv
// Shared sizing constants and state encoding for the index mask builder.
package index_mask_builder_pkg;

  localparam int WIDTH = 128;
  localparam int IDX_W = 8;
  localparam logic [IDX_W-1:0] NONE_CODE = 8'h80;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/index_mask_builder_onehot_dec.sv
// Combinational decode of a bit index into a WIDTH-wide one-hot vector.
module idx_onehot_dec #(
  parameter int WIDTH = 128,
  parameter int IDX_W = 8
) (
  input  logic [IDX_W-2:0] idx,
  output logic [WIDTH-1:0] onehot
);

  assign onehot = {{(WIDTH-1){1'b0}}, 1'b1} << idx;

endmodule

// File: rtl/index_mask_builder.sv
// Accumulates a frame of index beats into a bit mask with distinct-count,
// lowest-index and duplicate flags, then holds the result until accepted.
module index_mask_builder #(
  parameter int WIDTH = index_mask_builder_pkg::WIDTH,
  parameter int IDX_W = index_mask_builder_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mask,
  output logic [IDX_W-1:0] out_count,
  output logic [IDX_W-1:0] out_lowest,
  output logic             out_dup
);

  import index_mask_builder_pkg::state_t;
  import index_mask_builder_pkg::ACCUM;
  import index_mask_builder_pkg::HOLD;

  localparam logic [IDX_W-1:0] NONE = {1'b1, {(IDX_W-1){1'b0}}};

  state_t           state;
  logic [WIDTH-1:0] onehot;
  logic             idx_none;
  logic             hit;

  idx_onehot_dec #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_dec (
    .idx    (in_idx[IDX_W-2:0]),
    .onehot (onehot)
  );

  assign idx_none  = in_idx[IDX_W-1];
  assign hit       = |(out_mask & onehot);
  assign in_ready  = (state == ACCUM) && !rst;
  assign out_valid = (state == HOLD) && !rst;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ACCUM;
      out_mask   <= '0;
      out_count  <= '0;
      out_lowest <= NONE;
      out_dup    <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            if (!idx_none) begin
              if (hit) begin
                out_dup <= 1'b1;
              end else begin
                out_mask  <= out_mask | onehot;
                out_count <= out_count + IDX_W'(1);
                // NONE sorts above every real index, so one compare covers empty.
                if (in_idx < out_lowest) out_lowest <= in_idx;
              end
            end
            if (in_last) state <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state      <= ACCUM;
            out_mask   <= '0;
            out_count  <= '0;
            out_lowest <= NONE;
            out_dup    <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_index_mask_builder.sv
// Directed and randomized self-checking bench for index_mask_builder.
module tb_index_mask_builder;

  import index_mask_builder_pkg::NONE_CODE;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_idx;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_mask;
  logic [7:0]   out_count;
  logic [7:0]   out_lowest;
  logic         out_dup;

  int vectors = 0;
  int miscompares = 0;

  index_mask_builder #(.WIDTH(128), .IDX_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_idx     (in_idx),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_mask   (out_mask),
    .out_count  (out_count),
    .out_lowest (out_lowest),
    .out_dup    (out_dup)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Drive one accepted beat; called #1 after a rising edge, returns #1 after the next.
  task automatic send_beat(input logic [7:0] idx, input logic last);
    in_valid = 1'b1;
    in_idx   = idx;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_idx   = 8'h00;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_mask !== '0 ||
        out_count !== 8'd0 || out_lowest !== NONE_CODE || out_dup !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: valid=%b ready=%b count=%0d lowest=%h dup=%b mask=%h, required valid=0 ready=1 count=0 lowest=80 dup=0 mask=0",
               tag, out_valid, in_ready, out_count, out_lowest, out_dup, out_mask);
    end
  endtask

  function automatic logic [7:0] lsb_of(input logic [127:0] m);
    for (int i = 0; i < 128; i++) if (m[i]) return 8'(i);
    return 8'h80;
  endfunction

  function automatic logic [7:0] popcount(input logic [127:0] m);
    int c = 0;
    for (int i = 0; i < 128; i++) c += int'(m[i]);
    return 8'(c);
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_idx = 8'h00; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_mask !== '0 || out_count !== 8'd0 ||
        out_lowest !== 8'h80 || out_dup !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: ready=%b valid=%b count=%0d lowest=%h dup=%b, required 0 0 0 80 0",
               in_ready, out_valid, out_count, out_lowest, out_dup);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %b, required 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [127:0] em;
    em = '0; em[3] = 1'b1; em[5] = 1'b1; em[127] = 1'b1;
    send_beat(8'd5, 1'b0);
    send_beat(8'd3, 1'b0);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_no_early_valid: got %b, required 0", out_valid);
    end
    send_beat(8'd127, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_mask !== em || out_count !== 8'd3 ||
        out_lowest !== 8'd3 || out_dup !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_frame: valid=%b ready=%b count=%0d lowest=%0d dup=%b mask=%h, required 1 0 3 3 0 mask=%h",
               out_valid, in_ready, out_count, out_lowest, out_dup, out_mask, em);
    end
    handshake();
    check_cleared("basic_after_handshake");
  endtask

  task automatic test_dup();
    logic [127:0] em;
    em = '0; em[2] = 1'b1; em[9] = 1'b1;
    send_beat(8'd9, 1'b0);
    send_beat(8'd9, 1'b0);
    send_beat(8'd2, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || out_mask !== em || out_count !== 8'd2 ||
        out_lowest !== 8'd2 || out_dup !== 1'b1) begin
      miscompares++;
      $display("FAIL dup_frame: valid=%b count=%0d lowest=%0d dup=%b mask=%h, required 1 2 2 1 mask=%h",
               out_valid, out_count, out_lowest, out_dup, out_mask, em);
    end
    handshake();
    check_cleared("dup_after_handshake");
  endtask

  task automatic test_none_hold();
    send_beat(8'h80, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || out_mask !== '0 || out_count !== 8'd0 ||
        out_lowest !== 8'h80 || out_dup !== 1'b0) begin
      miscompares++;
      $display("FAIL none_frame: valid=%b count=%0d lowest=%h dup=%b, required 1 0 80 0",
               out_valid, out_count, out_lowest, out_dup);
    end
    in_valid = 1'b1; in_idx = 8'd5; in_last = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_mask !== '0 ||
          out_count !== 8'd0 || out_lowest !== 8'h80 || out_dup !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_stable cycle %0d: valid=%b ready=%b count=%0d lowest=%h dup=%b, required 1 0 0 80 0",
                 c, out_valid, in_ready, out_count, out_lowest, out_dup);
      end
    end
    in_valid = 1'b0; in_last = 1'b0; in_idx = 8'h00;
    handshake();
    check_cleared("none_after_handshake");
  endtask

  task automatic test_all_indices();
    for (int i = 127; i >= 0; i--) send_beat(8'(i), i == 0);
    vectors++;
    if (out_valid !== 1'b1 || out_mask !== {128{1'b1}} || out_count !== 8'd128 ||
        out_lowest !== 8'd0 || out_dup !== 1'b0) begin
      miscompares++;
      $display("FAIL all_indices: valid=%b count=%0d lowest=%0d dup=%b mask=%h, required 1 128 0 0 all ones",
               out_valid, out_count, out_lowest, out_dup, out_mask);
    end
    handshake();
    check_cleared("all_after_handshake");
  endtask

  task automatic test_reset_midframe();
    logic [127:0] em;
    send_beat(8'd1, 1'b0);
    send_beat(8'd4, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midframe_in_reset: valid=%b ready=%b, required 0 0", out_valid, in_ready);
    end
    rst = 1'b0;
    #1;
    check_cleared("midframe_after_reset");
    em = '0; em[6] = 1'b1;
    send_beat(8'd6, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || out_mask !== em || out_count !== 8'd1 ||
        out_lowest !== 8'd6 || out_dup !== 1'b0) begin
      miscompares++;
      $display("FAIL midframe_new_frame: valid=%b count=%0d lowest=%0d dup=%b mask=%h, required 1 1 6 0 mask=%h",
               out_valid, out_count, out_lowest, out_dup, out_mask, em);
    end
    // Reset while holding a result drops it without a handshake.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_cleared("hold_after_reset");
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [127:0] em;
    logic [7:0]   el, idx;
    logic         ed;
    int           ec, n;
    for (int f = 0; f < 8; f++) begin
      em = '0; el = 8'h80; ed = 1'b0; ec = 0;
      n = int'($urandom_range(1, 20));
      for (int b = 0; b < n; b++) begin
        if ($urandom_range(0, 7) == 0) idx = 8'h80;
        else idx = 8'($urandom_range(0, 31)) + ((f % 2 == 1) ? 8'd96 : 8'd0);
        if (!idx[7]) begin
          if (em[idx[6:0]]) ed = 1'b1;
          else begin
            em[idx[6:0]] = 1'b1;
            ec++;
            if (idx < el) el = idx;
          end
        end
        send_beat(idx, b == n - 1);
        if ($urandom_range(0, 3) == 0 && b != n - 1) begin
          @(posedge clk); #1;
        end
      end
      vectors++;
      if (out_valid !== 1'b1 || out_mask !== em || out_count !== 8'(ec) ||
          out_lowest !== el || out_dup !== ed) begin
        miscompares++;
        $display("FAIL random_model frame %0d: valid=%b count=%0d lowest=%h dup=%b mask=%h, required 1 %0d %h %b mask=%h",
                 f, out_valid, out_count, out_lowest, out_dup, out_mask, ec, el, ed, em);
      end
      vectors++;
      if (out_lowest !== lsb_of(out_mask) || out_count !== popcount(out_mask)) begin
        miscompares++;
        $display("FAIL random_scoreboard frame %0d: lowest=%h count=%0d, required lowest=%h count=%0d",
                 f, out_lowest, out_count, lsb_of(out_mask), popcount(out_mask));
      end
      handshake();
      check_cleared("random_after_handshake");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dup();
    test_none_hold();
    test_all_indices();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
